// File: rtl/watch_pkg.sv
// ============================================================================
// Module      : watch_pkg
// Description : Field maxima and widths shared by the watch time counters.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package watch_pkg;

    localparam int MSEC_MAX   = 99;
    localparam int SEC_MAX    = 59;
    localparam int MIN_MAX    = 59;
    localparam int HOUR_MAX   = 23;

    localparam int MSEC_WIDTH = 7;
    localparam int SEC_WIDTH  = 6;
    localparam int MIN_WIDTH  = 6;
    localparam int HOUR_WIDTH = 5;

endpackage

`default_nettype wire

// File: rtl/time_field_counter.sv
// ============================================================================
// Module      : time_field_counter
// Description : One modulo-(MAX+1) time field with ripple carry and a
//               carry-free adjust step.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module time_field_counter #(
    parameter int               MAX     = 59,
    parameter int               WIDTH   = 6,
    parameter logic [WIDTH-1:0] RST_VAL = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             carry_in,
    input  logic             inc,
    output logic [WIDTH-1:0] value,
    output logic             carry_out
);

    localparam logic [WIDTH-1:0] c_MAX = WIDTH'(MAX);

    logic [WIDTH-1:0] r_value;
    logic [WIDTH-1:0] w_next;
    logic             w_at_max;

    assign w_at_max = (r_value == c_MAX);
    assign w_next   = w_at_max ? '0 : r_value + WIDTH'(1);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_value <= RST_VAL;
        end else if (carry_in || inc) begin
            r_value <= w_next;
        end
    end

    // Carry is combinational so a full rollover ripples through every field on one edge;
    // an adjust step never carries.
    assign carry_out = carry_in & w_at_max;
    assign value     = r_value;

endmodule

`default_nettype wire

// File: rtl/watch_time_counter.sv
// ============================================================================
// Module      : watch_time_counter
// Description : 100 Hz time-base divider feeding cascaded msec/sec/min/hour
//               counters, with a set mode that freezes time and steps fields.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module watch_time_counter
    import watch_pkg::*;
#(
    parameter int CLK_FREQ  = 100_000_000,
    parameter int TICK_HZ   = 100,
    parameter int INIT_HOUR = 12
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  set_mode,
    input  logic                  inc_sec,
    input  logic                  inc_min,
    input  logic                  inc_hour,
    output logic [MSEC_WIDTH-1:0] msec,
    output logic [SEC_WIDTH-1:0]  sec,
    output logic [MIN_WIDTH-1:0]  min,
    output logic [HOUR_WIDTH-1:0] hour,
    output logic                  tick
);

    localparam int                 c_DIV      = CLK_FREQ / TICK_HZ;
    localparam int                 c_DIV_W    = (c_DIV > 1) ? $clog2(c_DIV) : 1;
    localparam logic [c_DIV_W-1:0] c_DIV_LAST = c_DIV_W'(c_DIV - 1);

    logic [c_DIV_W-1:0] r_div;
    logic               r_tick;
    logic               w_div_last;
    logic               w_run_tick;
    logic               w_msec_carry;
    logic               w_sec_carry;
    logic               w_min_carry;
    logic               w_hour_carry_unused;

    assign w_div_last = (r_div == c_DIV_LAST);
    // Set mode suppresses the tick even when the divider sits at its terminal count.
    assign w_run_tick = ~set_mode & w_div_last;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_div  <= '0;
            r_tick <= 1'b0;
        end else begin
            r_tick <= w_run_tick;
            if (!set_mode) begin
                r_div <= w_div_last ? '0 : r_div + c_DIV_W'(1);
            end
        end
    end

    time_field_counter #(
        .MAX     (MSEC_MAX),
        .WIDTH   (MSEC_WIDTH),
        .RST_VAL ('0)
    ) u_msec (
        .clk       (clk),
        .rst       (rst),
        .carry_in  (w_run_tick),
        .inc       (1'b0),
        .value     (msec),
        .carry_out (w_msec_carry)
    );

    time_field_counter #(
        .MAX     (SEC_MAX),
        .WIDTH   (SEC_WIDTH),
        .RST_VAL ('0)
    ) u_sec (
        .clk       (clk),
        .rst       (rst),
        .carry_in  (w_msec_carry),
        .inc       (set_mode & inc_sec),
        .value     (sec),
        .carry_out (w_sec_carry)
    );

    time_field_counter #(
        .MAX     (MIN_MAX),
        .WIDTH   (MIN_WIDTH),
        .RST_VAL ('0)
    ) u_min (
        .clk       (clk),
        .rst       (rst),
        .carry_in  (w_sec_carry),
        .inc       (set_mode & inc_min),
        .value     (min),
        .carry_out (w_min_carry)
    );

    time_field_counter #(
        .MAX     (HOUR_MAX),
        .WIDTH   (HOUR_WIDTH),
        .RST_VAL (HOUR_WIDTH'(INIT_HOUR))
    ) u_hour (
        .clk       (clk),
        .rst       (rst),
        .carry_in  (w_min_carry),
        .inc       (set_mode & inc_hour),
        .value     (hour),
        .carry_out (w_hour_carry_unused)
    );

    assign tick = r_tick;

endmodule

`default_nettype wire

// File: tb/tb_watch_time_counter.sv
// ============================================================================
// Module      : tb_watch_time_counter
// Description : Directed scoreboard bench for watch_time_counter (DIV = 10).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_watch_time_counter;

    logic       clk = 1'b0;
    logic       rst;
    logic       set_mode;
    logic       inc_sec;
    logic       inc_min;
    logic       inc_hour;
    logic [6:0] msec;
    logic [5:0] sec;
    logic [5:0] min;
    logic [4:0] hour;
    logic       tick;

    watch_time_counter #(
        .CLK_FREQ  (1000),
        .TICK_HZ   (100),
        .INIT_HOUR (12)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .set_mode (set_mode),
        .inc_sec  (inc_sec),
        .inc_min  (inc_min),
        .inc_hour (inc_hour),
        .msec     (msec),
        .sec      (sec),
        .min      (min),
        .hour     (hour),
        .tick     (tick)
    );

    always #5 clk = ~clk;

    typedef struct {
        string name;
        int    h;
        int    m;
        int    s;
        int    ms;
        logic  t;
    } exp_t;

    exp_t q[$];
    int   errors = 0;
    int   checks = 0;

    // At most one expectation is queued per clock cycle; the monitor consumes it mid-cycle.
    task automatic expect_state(input string name, input int h, input int m,
                                input int s, input int ms, input logic t);
        exp_t e;
        e.name = name; e.h = h; e.m = m; e.s = s; e.ms = ms; e.t = t;
        q.push_back(e);
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (q.size() > 0) begin
            e = q.pop_front();
            checks++;
            if ({hour, min, sec, msec, tick} !==
                {5'(e.h), 6'(e.m), 6'(e.s), 7'(e.ms), e.t}) begin
                errors++;
                $display("FAIL %s: got %0d:%0d:%0d.%0d tick=%b, want %0d:%0d:%0d.%0d tick=%b",
                         e.name, hour, min, sec, msec, tick, e.h, e.m, e.s, e.ms, e.t);
            end
        end
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic pulse(input int n, input logic ps, input logic pm, input logic ph);
        repeat (n) begin
            inc_sec  = ps;
            inc_min  = pm;
            inc_hour = ph;
            step(1);
            inc_sec  = 1'b0;
            inc_min  = 1'b0;
            inc_hour = 1'b0;
        end
    endtask

    initial begin
        int guard;
        rst = 1'b1; set_mode = 1'b0; inc_sec = 1'b0; inc_min = 1'b0; inc_hour = 1'b0;
        step(2);
        rst = 1'b0;
        expect_state("reset", 12, 0, 0, 0, 1'b0);
        step(9);  expect_state("pre_first_tick", 12, 0, 0, 0, 1'b0);
        step(1);  expect_state("first_tick", 12, 0, 0, 1, 1'b1);
        step(1);  expect_state("tick_one_cycle", 12, 0, 0, 1, 1'b0);

        // Preload 23:59:59 through set pulses; divider holds at 1.
        set_mode = 1'b1;
        pulse(11, 1'b0, 1'b0, 1'b1);
        pulse(59, 1'b0, 1'b1, 1'b0);
        pulse(59, 1'b1, 1'b0, 1'b0);
        expect_state("preload", 23, 59, 59, 1, 1'b0);
        set_mode = 1'b0;
        step(8);  expect_state("release_pre_tick", 23, 59, 59, 1, 1'b0);
        step(1);  expect_state("release_tick", 23, 59, 59, 2, 1'b1);
        repeat (96) step(10);
        expect_state("at_98", 23, 59, 59, 98, 1'b1);
        step(10); expect_state("at_99", 23, 59, 59, 99, 1'b1);
        step(9);  expect_state("before_rollover", 23, 59, 59, 99, 1'b0);
        step(1);  expect_state("full_rollover", 0, 0, 0, 0, 1'b1);

        // Long freeze with the divider at 3.
        step(3);  expect_state("pre_hold", 0, 0, 0, 0, 1'b0);
        set_mode = 1'b1;
        for (int i = 0; i < 50; i++) begin
            step(1);
            expect_state("hold", 0, 0, 0, 0, 1'b0);
        end
        set_mode = 1'b0;
        step(6);  expect_state("resume_pre_tick", 0, 0, 0, 0, 1'b0);
        step(1);  expect_state("resume_tick", 0, 0, 0, 1, 1'b1);

        // Freeze exactly while the divider sits at its terminal count.
        step(9);  expect_state("div_last", 0, 0, 0, 1, 1'b0);
        set_mode = 1'b1;
        step(1);  expect_state("hold_at_last", 0, 0, 0, 1, 1'b0);
        step(4);  expect_state("hold_at_last_4", 0, 0, 0, 1, 1'b0);
        set_mode = 1'b0;
        step(1);  expect_state("resume_from_last", 0, 0, 0, 2, 1'b1);

        // Adjust pulses.
        pulse(1, 1'b0, 1'b1, 1'b0);
        expect_state("run_inc_ignored", 0, 0, 0, 2, 1'b0);
        set_mode = 1'b1;
        pulse(1, 1'b1, 1'b1, 1'b1);
        expect_state("inc_all", 1, 1, 1, 2, 1'b0);
        pulse(58, 1'b1, 1'b0, 1'b0);
        expect_state("sec_59", 1, 1, 59, 2, 1'b0);
        pulse(1, 1'b1, 1'b0, 1'b0);
        expect_state("sec_wrap", 1, 1, 0, 2, 1'b0);
        pulse(22, 1'b0, 1'b0, 1'b1);
        expect_state("hour_23", 23, 1, 0, 2, 1'b0);
        pulse(1, 1'b0, 1'b0, 1'b1);
        expect_state("hour_wrap", 0, 1, 0, 2, 1'b0);

        // Preload 01:23:45, count to .67, reset asynchronously in the tick cycle.
        pulse(1, 1'b0, 1'b0, 1'b1);
        pulse(22, 1'b0, 1'b1, 1'b0);
        pulse(45, 1'b1, 1'b0, 1'b0);
        expect_state("preload2", 1, 23, 45, 2, 1'b0);
        set_mode = 1'b0;
        step(9);
        repeat (63) step(10);
        step(4);  expect_state("mid_count", 1, 23, 45, 66, 1'b0);
        step(6);
        expect_state("async_reset", 12, 0, 0, 0, 1'b0);
        #1 rst = 1'b1;
        step(1);  expect_state("reset_held", 12, 0, 0, 0, 1'b0);
        rst = 1'b0;
        step(9);  expect_state("post_reset_pre_tick", 12, 0, 0, 0, 1'b0);
        step(1);  expect_state("post_reset_tick", 12, 0, 0, 1, 1'b1);

        guard = 0;
        while (q.size() > 0 && guard < 20) begin
            @(posedge clk);
            guard++;
        end
        if (q.size() > 0) begin
            checks++;
            errors++;
            $display("FAIL drain: %0d expectations pending, want 0", q.size());
        end
        @(posedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire
